sprite_compositor: RTL and testbench

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_compositor_if.sv | 27 ++
 rtl/sprite_hit_unit.sv | 37 +++
 rtl/sprite_compositor.sv | 142 ++++++++++++++
 tb/tb_sprite_compositor.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and default constants for the sprite compositor.
package sprite_pkg;

    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_SPR_W       = 32;
    localparam int DEF_SPR_H       = 32;
    localparam int DEF_IDX_W       = 4;
    localparam int DEF_TRANSP_IDX  = 0;
    localparam int COORD_W         = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               en;
        logic               flip;
    } sprite_cfg_t;

    // A single-sprite build still needs a 1-bit select field.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Shadow-register configuration bus for the sprite compositor.
interface sprite_compositor_if
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES
);
    localparam int SEL_W = sel_width(NUM_SPRITES);

    logic                   cfg_we;
    logic [SEL_W-1:0]       cfg_sel;
    logic [COORD_W-1:0]     cfg_x;
    logic [COORD_W-1:0]     cfg_y;
    logic                   cfg_en;
    logic                   cfg_flip;
    logic [NUM_SPRITES-1:0] cfg_pending;

    modport master (
        output cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en, cfg_flip,
        input  cfg_pending
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_x, cfg_y, cfg_en, cfg_flip,
        output cfg_pending
    );

endinterface

// File: rtl/sprite_hit_unit.sv
// Per-sprite hit test and local-coordinate to sprite-memory address mapping.
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int SPR_W = DEF_SPR_W,
    parameter int SPR_H = DEF_SPR_H,
    localparam int AW   = $clog2(SPR_W * SPR_H)
) (
    input  sprite_cfg_t        cfg,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               hit,
    output logic [AW-1:0]      addr
);
    localparam int LXW = $clog2(SPR_W);
    localparam int LYW = $clog2(SPR_H);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic [LXW-1:0]   dx;
    logic [LXW-1:0]   lx;
    logic [LYW-1:0]   ly;

    // One extra bit keeps x+SPR_W from wrapping for sprites near the right/bottom edge.
    always_comb begin
        x_end = {1'b0, cfg.x} + (COORD_W+1)'(SPR_W);
        y_end = {1'b0, cfg.y} + (COORD_W+1)'(SPR_H);
        hit   = cfg.en
              && (draw_x >= cfg.x) && ({1'b0, draw_x} < x_end)
              && (draw_y >= cfg.y) && ({1'b0, draw_y} < y_end);
        dx    = draw_x[LXW-1:0] - cfg.x[LXW-1:0];
        lx    = cfg.flip ? ~dx : dx;
        ly    = draw_y[LYW-1:0] - cfg.y[LYW-1:0];
        addr  = {ly, lx};
    end

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: double-buffered config, 3-stage pixel pipeline, collision flags.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int TRANSP_IDX  = DEF_TRANSP_IDX,
    localparam int AW         = $clog2(SPR_W * SPR_H),
    localparam int SEL_W      = sel_width(NUM_SPRITES)
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         pixel_en,
    input  logic [COORD_W-1:0]           DrawX,
    input  logic [COORD_W-1:0]           DrawY,
    input  logic                         blank,
    input  logic                         frame_start,
    sprite_compositor_if.slave           cfg,
    output logic [NUM_SPRITES*AW-1:0]    spr_addr,
    input  logic [NUM_SPRITES*IDX_W-1:0] spr_data,
    output logic [IDX_W-1:0]             pix_idx,
    output logic [SEL_W-1:0]             pix_sprite,
    output logic                         pix_hit,
    output logic [NUM_SPRITES-1:0]       coll_status
);
    localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSP_IDX);

    sprite_cfg_t shadow [NUM_SPRITES];
    sprite_cfg_t active [NUM_SPRITES];

    logic [NUM_SPRITES-1:0]       hit_c;
    logic [NUM_SPRITES*AW-1:0]    addr_c;
    logic [NUM_SPRITES-1:0]       s1_hit;
    logic                         s1_blank;
    logic [NUM_SPRITES*IDX_W-1:0] s2_data;
    logic [NUM_SPRITES-1:0]       s2_hit;
    logic                         s2_blank;
    logic [NUM_SPRITES-1:0]       opaque;
    logic                         multi;
    logic                         win_found;
    logic [IDX_W-1:0]             win_idx;
    logic [SEL_W-1:0]             win_sel;
    logic [NUM_SPRITES-1:0]       coll_run;

    // Commit copies the pre-write shadow; a same-cycle write lands in the shadow and stays pending.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            cfg.cfg_pending <= '0;
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    active[i] <= shadow[i];
                end
                cfg.cfg_pending <= '0;
            end
            if (cfg.cfg_we && (int'(cfg.cfg_sel) < NUM_SPRITES)) begin
                shadow[cfg.cfg_sel] <= '{x: cfg.cfg_x, y: cfg.cfg_y,
                                         en: cfg.cfg_en, flip: cfg.cfg_flip};
                cfg.cfg_pending[cfg.cfg_sel] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit_unit #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H)
        ) u_hit (
            .cfg    (active[g]),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (hit_c[g]),
            .addr   (addr_c[g*AW +: AW])
        );
    end

    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque[i] = s2_hit[i] && (s2_data[i*IDX_W +: IDX_W] != TRANSP);
        end
        multi = |(opaque & (opaque - NUM_SPRITES'(1)));
    end

    // Scanning downward leaves the lowest-numbered opaque sprite as the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = TRANSP;
        win_sel   = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_found = 1'b1;
                win_idx   = s2_data[i*IDX_W +: IDX_W];
                win_sel   = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            spr_addr   <= '0;
            s1_hit     <= '0;
            s1_blank   <= 1'b0;
            s2_data    <= '0;
            s2_hit     <= '0;
            s2_blank   <= 1'b0;
            pix_hit    <= 1'b0;
            pix_idx    <= TRANSP;
            pix_sprite <= '0;
        end else if (pixel_en) begin
            spr_addr   <= addr_c;
            s1_hit     <= hit_c;
            s1_blank   <= blank;
            s2_data    <= spr_data;
            s2_hit     <= s1_hit;
            s2_blank   <= s1_blank;
            pix_hit    <= win_found && s2_blank;
            pix_idx    <= (win_found && s2_blank) ? win_idx : TRANSP;
            pix_sprite <= (win_found && s2_blank) ? win_sel : '0;
        end
    end

    // A collision seen on the frame_start cycle seeds the new frame's running bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            coll_run    <= '0;
            coll_status <= '0;
        end else if (frame_start) begin
            coll_status <= coll_run;
            coll_run    <= (pixel_en && multi) ? opaque : '0;
        end else if (pixel_en && multi) begin
            coll_run    <= coll_run | opaque;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor with hand-computed expectations.
module tb_sprite_compositor;

    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int IW  = 4;
    localparam int SW  = 2;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            pixel_en;
    logic [9:0]      DrawX;
    logic [9:0]      DrawY;
    logic            blank;
    logic            frame_start;
    logic [N*AW-1:0] spr_addr;
    logic [N*IW-1:0] spr_data;
    logic [IW-1:0]   pix_idx;
    logic [SW-1:0]   pix_sprite;
    logic            pix_hit;
    logic [N-1:0]    coll_status;
    logic [IW-1:0]   d [N];

    int n_cmp  = 0;
    int n_fail = 0;

    sprite_compositor_if #(.NUM_SPRITES(N)) ifc ();

    sprite_compositor dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pixel_en    (pixel_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_start (frame_start),
        .cfg         (ifc.slave),
        .spr_addr    (spr_addr),
        .spr_data    (spr_data),
        .pix_idx     (pix_idx),
        .pix_sprite  (pix_sprite),
        .pix_hit     (pix_hit),
        .coll_status (coll_status)
    );

    always #10 Clk = ~Clk;

    assign spr_data = {d[3], d[2], d[1], d[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic cfg_write(input int sel, input int x, input int y, input bit en, input bit flip);
        ifc.cfg_sel  = 2'(sel);
        ifc.cfg_x    = 10'(x);
        ifc.cfg_y    = 10'(y);
        ifc.cfg_en   = en;
        ifc.cfg_flip = flip;
        ifc.cfg_we   = 1'b1;
        tick();
        ifc.cfg_we   = 1'b0;
    endtask

    task automatic frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pix_step(input int x, input int y);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        blank    = 1'b1;
        pixel_en = 1'b1;
        tick();
    endtask

    // Present one pixel, then two misses; outputs then reflect the presented pixel.
    task automatic probe(input int x, input int y);
        pix_step(x, y);
        pix_step(0, 0);
        pix_step(0, 0);
    endtask

    task automatic check_out(input string tag, input bit hit, input int idx, input int spr);
        check({tag, "_hit"}, 32'(pix_hit), 32'(hit));
        check({tag, "_idx"}, 32'(pix_idx), 32'(idx));
        check({tag, "_spr"}, 32'(pix_sprite), 32'(spr));
    endtask

    initial begin
        Reset        = 1'b1;
        pixel_en     = 1'b0;
        DrawX        = '0;
        DrawY        = '0;
        blank        = 1'b0;
        frame_start  = 1'b0;
        ifc.cfg_we   = 1'b0;
        ifc.cfg_sel  = '0;
        ifc.cfg_x    = '0;
        ifc.cfg_y    = '0;
        ifc.cfg_en   = 1'b0;
        ifc.cfg_flip = 1'b0;
        for (int i = 0; i < N; i++) d[i] = 4'd0;
        tick();
        tick();
        check_out("rst", 1'b0, 0, 0);
        check("rst_pending", 32'(ifc.cfg_pending), 32'd0);
        check("rst_coll", 32'(coll_status), 32'd0);
        check("rst_addr", 32'(spr_addr[31:0]), 32'd0);
        Reset = 1'b0;

        // Sprite 0 at (100,50), solid index 5; exact 3-pixel_en latency and stall hold
        d[0] = 4'd5;
        cfg_write(0, 100, 50, 1'b1, 1'b0);
        check("pend_set", 32'(ifc.cfg_pending), 32'b0001);
        frame();
        check("pend_clr", 32'(ifc.cfg_pending), 32'd0);
        pix_step(0, 0);
        pix_step(0, 0);
        pix_step(0, 0);
        pix_step(100, 50);
        check("lat_e1", 32'(pix_hit), 32'd0);
        check("addr_tl", 32'(spr_addr[AW-1:0]), 32'd0);
        pix_step(132, 50);
        check("lat_e2", 32'(pix_hit), 32'd0);
        pixel_en = 1'b0;
        tick();
        check("stall_noadv", 32'(pix_hit), 32'd0);
        pix_step(132, 50);
        check_out("lat_e3", 1'b1, 5, 0);
        pixel_en = 1'b0;
        tick();
        check_out("stall_hold", 1'b1, 5, 0);
        pix_step(0, 0);
        check_out("right_miss", 1'b0, 0, 0);

        // blank low suppresses an otherwise opaque hit
        DrawX = 10'd100; DrawY = 10'd50; blank = 1'b0; pixel_en = 1'b1;
        tick();
        pix_step(0, 0);
        pix_step(0, 0);
        check_out("blank_off", 1'b0, 0, 0);

        // Overlap with sprite 0 transparent: sprite 1 wins, no collision
        cfg_write(1, 110, 60, 1'b1, 1'b0);
        frame();
        d[0] = 4'd0; d[1] = 4'd7;
        probe(115, 65);
        check_out("transp_win", 1'b1, 7, 1);
        frame();
        check("coll_none", 32'(coll_status), 32'b0000);

        // Both opaque: sprite 0 wins, collision reported only after frame_start
        d[0] = 4'd5;
        probe(115, 65);
        check_out("prio_win", 1'b1, 5, 0);
        check("coll_midframe", 32'(coll_status), 32'b0000);
        frame();
        check("coll_both", 32'(coll_status), 32'b0011);
        frame();
        check("coll_clean", 32'(coll_status), 32'b0000);

        // Flip and right-edge address mapping
        cfg_write(0, 0, 50, 1'b1, 1'b1);
        frame();
        pix_step(0, 50);
        check("addr_flip", 32'(spr_addr[AW-1:0]), 32'd31);
        pix_step(7, 52);
        check("addr_flip2", 32'(spr_addr[AW-1:0]), 32'd88);
        pix_step(0, 0);
        check_out("flip_hit", 1'b1, 5, 0);
        cfg_write(0, 0, 50, 1'b1, 1'b0);
        frame();
        pix_step(0, 50);
        check("addr_noflip", 32'(spr_addr[AW-1:0]), 32'd0);
        cfg_write(0, 1010, 50, 1'b1, 1'b0);
        frame();
        pix_step(1023, 50);
        check("addr_edge", 32'(spr_addr[AW-1:0]), 32'd13);
        pix_step(5, 50);
        pix_step(0, 0);
        check("edge_hit", 32'(pix_hit), 32'd1);
        pix_step(0, 0);
        check("nowrap_miss", 32'(pix_hit), 32'd0);

        // Same-cycle write and commit
        cfg_write(0, 100, 50, 1'b1, 1'b0);
        frame();
        ifc.cfg_sel = 2'd0; ifc.cfg_x = 10'd200; ifc.cfg_y = 10'd50;
        ifc.cfg_en = 1'b1; ifc.cfg_flip = 1'b0; ifc.cfg_we = 1'b1;
        frame_start = 1'b1;
        tick();
        ifc.cfg_we = 1'b0; frame_start = 1'b0;
        check("race_pend", 32'(ifc.cfg_pending), 32'b0001);
        probe(100, 50);
        check("race_old_x", 32'(pix_hit), 32'd1);
        probe(200, 50);
        check("race_new_miss", 32'(pix_hit), 32'd0);
        frame();
        check("race_pend_clr", 32'(ifc.cfg_pending), 32'd0);
        probe(200, 50);
        check("race_new_x", 32'(pix_hit), 32'd1);
        probe(100, 50);
        check("race_old_miss", 32'(pix_hit), 32'd0);

        // Reset during an active hit with collision and pending flags set
        cfg_write(1, 200, 50, 1'b1, 1'b0);
        frame();
        pix_step(200, 50);
        pix_step(200, 50);
        pix_step(200, 50);
        check_out("pre_rst", 1'b1, 5, 0);
        frame();
        check("pre_rst_coll", 32'(coll_status), 32'b0011);
        cfg_write(2, 300, 300, 1'b1, 1'b0);
        check("pre_rst_pend", 32'(ifc.cfg_pending), 32'b0100);
        Reset = 1'b1;
        pixel_en = 1'b0;
        frame_start = 1'b1;
        tick();
        Reset = 1'b0;
        frame_start = 1'b0;
        check_out("mid_rst", 1'b0, 0, 0);
        check("mid_rst_coll", 32'(coll_status), 32'd0);
        check("mid_rst_pend", 32'(ifc.cfg_pending), 32'd0);
        check("mid_rst_addr", 32'(spr_addr), 32'd0);
        pix_step(200, 50);
        pix_step(200, 50);
        pix_step(200, 50);
        check("post_rst_hit", 32'(pix_hit), 32'd0);
        frame();
        check("post_rst_coll", 32'(coll_status), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
